// File: rtl/dmem_responder.sv
// Word-addressed data RAM that serves one load or store at a time over a valid/ready
// request/response handshake, with a fixed access latency and word 0 mirrored on test_value.
module dmem_responder #(
   parameter int MIPS_SIZE = 32,
   parameter int DEPTH     = 64,
   parameter int LATENCY   = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [MIPS_SIZE-1:0]   req_addr,
   input  logic [MIPS_SIZE-1:0]   req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [MIPS_SIZE-1:0]   rsp_rdata,
   output logic                   rsp_err,
   output logic [MIPS_SIZE/2-1:0] test_value
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                 state_q, state_d;
   logic                   live_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [MIPS_SIZE-1:0]   addr_q, addr_d;
   logic [MIPS_SIZE-1:0]   wdata_q, wdata_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [MIPS_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [MIPS_SIZE-1:0]   mem_q [DEPTH];
   logic [MIPS_SIZE-1:0]   mem_d [DEPTH];
   logic [AW-1:0]          idx;
   logic                   acc_err;

   // No wrap-around: any address bit above the word index makes the access an error.
   assign idx     = addr_q[AW+1:2];
   assign acc_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW+2)) != '0);

   // live_q holds req_ready low through the reset cycle itself.
   assign req_ready  = live_q && (state_q == IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign test_value = mem_q[0][MIPS_SIZE/2-1:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_d       = mem_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CW'(LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               if (acc_err) begin
                  rsp_err_d = 1'b1;
               end else if (we_q) begin
                  mem_d[idx] = wdata_q;
               end else begin
                  rsp_rdata_d = mem_q[idx];
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         live_q      <= 1'b0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         live_q      <= 1'b1;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end
endmodule
